// File: rtl/shift_reg_burst.sv
// Burst shift register: LOAD, and LEFT/RIGHT/ROTL by up to WIDTH single-bit steps.
// Define SHIFT_REG_ROTATE_EN to enable ROTL; otherwise mode 11 completes as a no-op.
module shift_reg_burst #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       mode_i,
  input  logic [WIDTH-1:0] par_i,
  input  logic [CNT_W-1:0] amt_i,
  input  logic             ser_i,
  output logic [WIDTH-1:0] P,
  output logic             ser_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_LEFT = 2'b01, OP_RIGHT = 2'b10, OP_ROTL = 2'b11} op_t;

  localparam logic [CNT_W-1:0] MAX_AMT = CNT_W'(WIDTH);

  state_t           state;
  op_t              op;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] amt_clamped;
  logic             is_shift;

  always_comb begin
    amt_clamped = (amt_i > MAX_AMT) ? MAX_AMT : amt_i;
    is_shift    = 1'b0;
    case (op_t'(mode_i))
      OP_LEFT, OP_RIGHT: is_shift = 1'b1;
`ifdef SHIFT_REG_ROTATE_EN
      OP_ROTL:           is_shift = 1'b1;
`endif
      default:           is_shift = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op     <= OP_LOAD;
      cnt    <= '0;
      P      <= '0;
      ser_o  <= 1'b0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            op     <= op_t'(mode_i);
            cnt    <= amt_clamped;
            busy_o <= 1'b1;
            // Shifts with a non-zero amount run in SHIFT; everything else finishes next cycle.
            if (is_shift && (amt_clamped != '0)) begin
              state <= SHIFT;
            end else begin
              state  <= DONE;
              done_o <= 1'b1;
              if (op_t'(mode_i) == OP_LOAD) P <= par_i;
            end
          end
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          case (op)
            OP_LEFT: begin
              P     <= {P[WIDTH-2:0], ser_i};
              ser_o <= P[WIDTH-1];
            end
            OP_RIGHT: begin
              P     <= {ser_i, P[WIDTH-1:1]};
              ser_o <= P[0];
            end
`ifdef SHIFT_REG_ROTATE_EN
            OP_ROTL: begin
              P     <= {P[WIDTH-2:0], P[WIDTH-1]};
              ser_o <= P[WIDTH-1];
            end
`endif
            default: ;
          endcase
          if (cnt == CNT_W'(1)) begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
          done_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_burst.sv
// Bench for shift_reg_burst (WIDTH=8): spec vector table, reset-abort sequence, random ops vs arithmetic model.
module tb_shift_reg_burst;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start_i;
  logic [1:0]       mode_i;
  logic [WIDTH-1:0] par_i;
  logic [CNT_W-1:0] amt_i;
  logic             ser_i;
  logic [WIDTH-1:0] P;
  logic             ser_o;
  logic             busy_o;
  logic             done_o;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] mp;
  logic       ms;

`ifdef SHIFT_REG_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  shift_reg_burst #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i), .par_i(par_i),
    .amt_i(amt_i), .ser_i(ser_i), .P(P), .ser_o(ser_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    logic [7:0] par;
    logic [3:0] amt;
    logic       fill;
    bit         noise;
    logic [7:0] exp_p;
    logic       exp_ser;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int steps(input logic [1:0] op, input logic [3:0] amt);
    if (op == 2'b00) return 0;
    if (op == 2'b11 && !ROT) return 0;
    return (int'(amt) > WIDTH) ? WIDTH : int'(amt);
  endfunction

  // Result {ser_o, P} after k steps of op applied to (p, s), computed as whole-word arithmetic.
  function automatic logic [8:0] model(input logic [1:0] op, input logic [7:0] p, input logic s,
                                       input logic [7:0] par, input logic fill, input int k);
    int pi, po, so;
    pi = int'(p);
    po = pi;
    so = int'(s);
    if (op == 2'b00) return {s, par};
    if (k == 0) return {s, p};
    case (op)
      2'b01: begin
        so = (pi >> (8 - k)) & 1;
        po = ((pi << k) | (fill ? ((1 << k) - 1) : 0)) & 255;
      end
      2'b10: begin
        so = (pi >> (k - 1)) & 1;
        po = (pi >> k) | (fill ? (255 & ~(255 >> k)) : 0);
      end
      default: begin
        po = ((pi << k) | (pi >> (8 - k))) & 255;
        so = po & 1;
      end
    endcase
    return {so[0], po[7:0]};
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [7:0] par, input logic [3:0] amt,
                        input logic fill, input bit noise);
    int n;
    logic [8:0] r;
    n = steps(op, amt);
    @(negedge clk);
    start_i = 1'b1; mode_i = op; par_i = par; amt_i = amt; ser_i = fill;
    for (int j = 0; j <= n + 1; j++) begin
      @(posedge clk);
      #1;
      start_i = noise && (j <= n) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) begin
        mode_i = 2'($urandom);
        par_i  = 8'($urandom);
        amt_i  = 4'($urandom);
      end
      r = model(op, mp, ms, par, fill, (j < n) ? j : n);
      chk("P", 32'(P), 32'(r[7:0]));
      chk("ser_o", 32'(ser_o), 32'(r[8]));
      chk("busy_o", 32'(busy_o), 32'(j <= n));
      chk("done_o", 32'(done_o), 32'(j == n));
    end
    start_i = 1'b0;
    {ms, mp} = model(op, mp, ms, par, fill, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_P", 32'(P), 32'h0);
    chk("rst_ser_o", 32'(ser_o), 32'h0);
    chk("rst_busy_o", 32'(busy_o), 32'h0);
    chk("rst_done_o", 32'(done_o), 32'h0);
    mp = 8'h00;
    ms = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    tbl[0] = '{mode: 2'b00, par: 8'hA5, amt: 4'd0,  fill: 1'b0, noise: 1'b0, exp_p: 8'hA5, exp_ser: 1'b0};
    tbl[1] = '{mode: 2'b01, par: 8'h00, amt: 4'd3,  fill: 1'b1, noise: 1'b0, exp_p: 8'h2F, exp_ser: 1'b1};
    tbl[2] = '{mode: 2'b00, par: 8'hA5, amt: 4'd9,  fill: 1'b0, noise: 1'b0, exp_p: 8'hA5, exp_ser: 1'b1};
    tbl[3] = '{mode: 2'b10, par: 8'h3C, amt: 4'd12, fill: 1'b0, noise: 1'b1, exp_p: 8'h00, exp_ser: 1'b1};
    tbl[4] = '{mode: 2'b00, par: 8'h81, amt: 4'd0,  fill: 1'b0, noise: 1'b0, exp_p: 8'h81, exp_ser: 1'b1};
    tbl[5] = '{mode: 2'b11, par: 8'h00, amt: 4'd1,  fill: 1'b0, noise: 1'b0,
               exp_p: ROT ? 8'h03 : 8'h81, exp_ser: 1'b1};

    rst = 1'b1; start_i = 1'b0; mode_i = 2'b00; par_i = '0; amt_i = '0; ser_i = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();

    foreach (tbl[i]) begin
      run_op(tbl[i].mode, tbl[i].par, tbl[i].amt, tbl[i].fill, tbl[i].noise);
      chk($sformatf("tbl%0d_P", i), 32'(P), 32'(tbl[i].exp_p));
      chk($sformatf("tbl%0d_ser_o", i), 32'(ser_o), 32'(tbl[i].exp_ser));
    end

    // Amount 0 on a shift mode completes immediately without touching P.
    run_op(2'b01, 8'h00, 4'd0, 1'b1, 1'b0);

    // Reset aborts a RIGHT 5 after its second step: no done pulse afterwards.
    run_op(2'b00, 8'hF0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    start_i = 1'b1; mode_i = 2'b10; amt_i = 4'd5; ser_i = 1'b1;
    @(posedge clk); #1; start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_midP", 32'(P), 32'hFC);
    chk("abort_busy", 32'(busy_o), 32'h1);
    do_reset();
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 32'(done_o), 32'h0);
      chk("abort_idle", 32'(busy_o), 32'h0);
    end

    for (int t = 0; t < 150; t++) begin
      run_op(2'($urandom), 8'($urandom), 4'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
